green_decode_wb: RTL

Parametrised decode/write-back stage for the green datapath. It accepts one 16-bit instruction per handshake and decodes the opcode. It owns an internal register file of NREG registers of DW bits and a ZNC flag register, and performs LD and INC write-back itself, with the increment and flag computation done internally. It issues store and branch requests through a registered valid/ready output slot toward the memory and PC logic.

---
 rtl/green_decode_wb_if.sv | 27 ++
 rtl/green_decode_wb.sv | 87 ++++++++
 2 files changed

// File: rtl/green_decode_wb_if.sv
// Handshake and payload bundle between the green decode/write-back stage,
// its instruction source and the memory/PC consumer.
interface green_decode_wb_if #(
  parameter int DW = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   ins;
  logic [DW-1:0] ld_data;
  logic          br_in;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    out_op;
  logic          we;
  logic [DW-1:0] st_data;
  logic          br_out;

  modport slave (
    input  in_valid, ins, ld_data, br_in, out_ready,
    output in_ready, out_valid, out_op, we, st_data, br_out
  );

  modport master (
    output in_valid, ins, ld_data, br_in, out_ready,
    input  in_ready, out_valid, out_op, we, st_data, br_out
  );
endinterface

// File: rtl/green_decode_wb.sv
// Decode/write-back stage: owns the register file and ZNC flags, performs LD/INC
// write-back and presents ST/BR requests through a registered valid/ready slot.
module green_decode_wb #(
  parameter  int DW   = 16,
  parameter  int NREG = 2,
  localparam int RSW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  green_decode_wb_if.slave bus,
  output logic [2:0]      znc,
  input  logic [RSW-1:0]  rd_sel,
  output logic [DW-1:0]   rd_data
);

  typedef enum logic [3:0] {
    OP_LD  = 4'h0,
    OP_ST  = 4'h1,
    OP_INC = 4'h2,
    OP_BR  = 4'h3
  } op_e;

  logic [DW-1:0]  regs [NREG];
  logic [2:0]     flags;
  logic           slot_valid;
  logic [3:0]     slot_op;
  logic           slot_we;
  logic [DW-1:0]  slot_st;
  logic           slot_br;

  logic           accept;
  logic [3:0]     op;
  logic [RSW-1:0] sel;
  logic [DW-1:0]  cur;
  logic [DW:0]    inc_sum;
  logic           unused_ins;

  assign op         = bus.ins[15:12];
  assign sel        = bus.ins[11 -: RSW];
  assign unused_ins = ^bus.ins[11-RSW:0];
  assign cur        = regs[sel];
  assign inc_sum    = {1'b0, cur} + {{DW{1'b0}}, 1'b1};

  assign bus.in_ready = !slot_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  assign bus.out_valid = slot_valid;
  assign bus.out_op    = slot_op;
  assign bus.we        = slot_we;
  assign bus.st_data   = slot_st;
  assign bus.br_out    = slot_br;
  assign znc           = flags;
  assign rd_data       = regs[rd_sel];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
      flags      <= '0;
      slot_valid <= 1'b0;
      slot_op    <= '0;
      slot_we    <= 1'b0;
      slot_st    <= '0;
      slot_br    <= 1'b0;
    end else if (accept) begin
      // Slot captures the pre-edge register value, so a store right after an
      // INC/LD sees the written value without any forwarding path.
      slot_valid <= 1'b1;
      slot_op    <= op;
      slot_we    <= (op == OP_ST);
      slot_st    <= cur;
      slot_br    <= (op == OP_BR) && bus.br_in;
      case (op)
        OP_LD:  regs[sel] <= bus.ld_data;
        OP_INC: begin
          regs[sel] <= inc_sum[DW-1:0];
          flags     <= {(inc_sum[DW-1:0] == '0), inc_sum[DW-1], inc_sum[DW]};
        end
        default: ;
      endcase
    end else if (bus.out_ready) begin
      slot_valid <= 1'b0;
      slot_we    <= 1'b0;
      slot_br    <= 1'b0;
    end
  end

endmodule
